// File: rtl/matrix_cmd_seq.sv
// Matrix command sequencer: turns GL matrix commands plus a 128-bit row
// stream into the strobe/data timing of the matrix stack and the 4x4
// multiplier, tracking per-stack depth and rejecting overflow/underflow.
//
// state    | meaning
// RST_WAIT | post-reset hold, cmd_ready low while the stack settles
// IDLE     | cmd_ready high, accepting commands
// GATHER   | collecting four operand rows into the buffer
// WB       | one-cycle overwrite of the top matrix from the buffer
// PUSH0..3 | streaming buffer rows to the stack, push strobe in PUSH0
// MSTART   | one-cycle multiplier start
// MWAIT    | waiting for the product
// STROBE   | one-cycle load-identity or pop strobe
module matrix_cmd_seq #(
    parameter int MV_DEPTH = 32,
    parameter int PJ_DEPTH = 2,
    parameter int RST_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_mode,
    input  logic         row_valid,
    output logic         row_ready,
    input  logic [127:0] row_data,
    output logic         matrix_mode,
    output logic         load_id_en,
    output logic         load_en,
    output logic         push_en,
    output logic         pop_en,
    output logic         write_en,
    output logic [127:0] data_out,
    output logic [127:0] wr_row_0,
    output logic [127:0] wr_row_1,
    output logic [127:0] wr_row_2,
    output logic [127:0] wr_row_3,
    input  logic [127:0] peek_0,
    input  logic [127:0] peek_1,
    input  logic [127:0] peek_2,
    input  logic [127:0] peek_3,
    output logic         mul_start,
    output logic [127:0] op_row_0,
    output logic [127:0] op_row_1,
    output logic [127:0] op_row_2,
    output logic [127:0] op_row_3,
    input  logic         mul_done,
    input  logic [127:0] mul_res_0,
    input  logic [127:0] mul_res_1,
    input  logic [127:0] mul_res_2,
    input  logic [127:0] mul_res_3,
    output logic         err_ovf,
    output logic         err_unf,
    output logic         busy
);

    localparam int MAXD = (MV_DEPTH > PJ_DEPTH) ? MV_DEPTH : PJ_DEPTH;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int HW   = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [CW-1:0] MV_MAX    = CW'(MV_DEPTH);
    localparam logic [CW-1:0] PJ_MAX    = CW'(PJ_DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);

    localparam logic [2:0] OP_MODE = 3'd1;
    localparam logic [2:0] OP_LDID = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_POP  = 3'd5;
    localparam logic [2:0] OP_MULT = 3'd6;

    typedef enum logic [3:0] {
        RST_WAIT, IDLE, GATHER, WB, PUSH0, PUSH1, PUSH2, PUSH3, MSTART, MWAIT, STROBE
    } state_t;

    state_t         state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [CW-1:0]  mv_cnt_q, mv_cnt_d, pj_cnt_q, pj_cnt_d, cur_cnt, cur_max;
    logic [1:0]     idx_q, idx_d;
    logic           is_mult_q, is_mult_d;
    logic [127:0]   mbuf_q [4];
    logic [127:0]   mbuf_d [4];
    logic [127:0]   data_out_q, data_out_d;
    logic           mode_q, mode_d;
    logic           cmd_ready_q, cmd_ready_d, row_ready_q, row_ready_d;
    logic           load_id_q, load_id_d, load_q, load_d, pop_q, pop_d;
    logic           write_q, write_d, mul_start_q, mul_start_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;

    // Next-state, counter, buffer and registered-output decode
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        mv_cnt_d    = mv_cnt_q;
        pj_cnt_d    = pj_cnt_q;
        idx_d       = idx_q;
        is_mult_d   = is_mult_q;
        mbuf_d      = mbuf_q;
        data_out_d  = data_out_q;
        mode_d      = mode_q;
        cmd_ready_d = 1'b0;
        row_ready_d = 1'b0;
        load_id_d   = 1'b0;
        load_d      = 1'b0;
        pop_d       = 1'b0;
        write_d     = 1'b0;
        mul_start_d = 1'b0;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        cur_cnt     = mode_q ? pj_cnt_q : mv_cnt_q;
        cur_max     = mode_q ? PJ_MAX : MV_MAX;

        unique case (state_q)
            RST_WAIT: begin
                if (hold_q == '0) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    unique case (cmd_op)
                        OP_MODE: mode_d = cmd_mode;
                        OP_LDID: begin
                            load_id_d   = 1'b1;
                            cmd_ready_d = 1'b0;
                            state_d     = STROBE;
                        end
                        OP_LOAD, OP_MULT: begin
                            is_mult_d   = (cmd_op == OP_MULT);
                            idx_d       = 2'd0;
                            row_ready_d = 1'b1;
                            cmd_ready_d = 1'b0;
                            state_d     = GATHER;
                        end
                        OP_PUSH: begin
                            if (cur_cnt == cur_max) begin
                                ovf_d = 1'b1;
                            end else begin
                                mbuf_d[0]   = peek_0;
                                mbuf_d[1]   = peek_1;
                                mbuf_d[2]   = peek_2;
                                mbuf_d[3]   = peek_3;
                                data_out_d  = peek_0;
                                load_d      = 1'b1;
                                cmd_ready_d = 1'b0;
                                state_d     = PUSH0;
                                if (mode_q) pj_cnt_d = pj_cnt_q + CNT_ONE;
                                else        mv_cnt_d = mv_cnt_q + CNT_ONE;
                            end
                        end
                        OP_POP: begin
                            if (cur_cnt == CNT_ONE) begin
                                unf_d = 1'b1;
                            end else begin
                                pop_d       = 1'b1;
                                cmd_ready_d = 1'b0;
                                state_d     = STROBE;
                                if (mode_q) pj_cnt_d = pj_cnt_q - CNT_ONE;
                                else        mv_cnt_d = mv_cnt_q - CNT_ONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            GATHER: begin
                row_ready_d = 1'b1;
                if (row_valid && row_ready_q) begin
                    mbuf_d[idx_q] = row_data;
                    idx_d         = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        row_ready_d = 1'b0;
                        if (is_mult_q) begin
                            mul_start_d = 1'b1;
                            state_d     = MSTART;
                        end else begin
                            write_d = 1'b1;
                            state_d = WB;
                        end
                    end
                end
            end
            MSTART: state_d = MWAIT;
            MWAIT: begin
                if (mul_done) begin
                    mbuf_d[0] = mul_res_0;
                    mbuf_d[1] = mul_res_1;
                    mbuf_d[2] = mul_res_2;
                    mbuf_d[3] = mul_res_3;
                    write_d   = 1'b1;
                    state_d   = WB;
                end
            end
            PUSH0: begin
                data_out_d = mbuf_q[1];
                state_d    = PUSH1;
            end
            PUSH1: begin
                data_out_d = mbuf_q[2];
                state_d    = PUSH2;
            end
            PUSH2: begin
                data_out_d = mbuf_q[3];
                state_d    = PUSH3;
            end
            WB, PUSH3, STROBE: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = RST_WAIT;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_WAIT;
            hold_q      <= HOLD_INIT;
            mv_cnt_q    <= CNT_ONE;
            pj_cnt_q    <= CNT_ONE;
            idx_q       <= 2'd0;
            is_mult_q   <= 1'b0;
            for (int i = 0; i < 4; i++) mbuf_q[i] <= '0;
            data_out_q  <= '0;
            mode_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            row_ready_q <= 1'b0;
            load_id_q   <= 1'b0;
            load_q      <= 1'b0;
            pop_q       <= 1'b0;
            write_q     <= 1'b0;
            mul_start_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            mv_cnt_q    <= mv_cnt_d;
            pj_cnt_q    <= pj_cnt_d;
            idx_q       <= idx_d;
            is_mult_q   <= is_mult_d;
            mbuf_q      <= mbuf_d;
            data_out_q  <= data_out_d;
            mode_q      <= mode_d;
            cmd_ready_q <= cmd_ready_d;
            row_ready_q <= row_ready_d;
            load_id_q   <= load_id_d;
            load_q      <= load_d;
            pop_q       <= pop_d;
            write_q     <= write_d;
            mul_start_q <= mul_start_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = ~cmd_ready_q;
    assign row_ready   = row_ready_q;
    assign matrix_mode = mode_q;
    assign load_id_en  = load_id_q;
    assign load_en     = load_q;
    assign push_en     = load_q;
    assign pop_en      = pop_q;
    assign write_en    = write_q;
    assign mul_start   = mul_start_q;
    assign err_ovf     = ovf_q;
    assign err_unf     = unf_q;
    assign data_out    = data_out_q;
    assign wr_row_0    = mbuf_q[0];
    assign wr_row_1    = mbuf_q[1];
    assign wr_row_2    = mbuf_q[2];
    assign wr_row_3    = mbuf_q[3];
    assign op_row_0    = mbuf_q[0];
    assign op_row_1    = mbuf_q[1];
    assign op_row_2    = mbuf_q[2];
    assign op_row_3    = mbuf_q[3];

endmodule

// File: tb/tb_matrix_cmd_seq.sv
// Bench for matrix_cmd_seq: directed scenarios followed by random command
// traffic, checked against a stack-depth model of the sequencer.
module tb_matrix_cmd_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0, cmd_mode = 1'b0;
    logic [2:0]   cmd_op = 3'd0;
    logic         row_valid = 1'b0, mul_done = 1'b0;
    logic [127:0] row_data = '0;
    logic [127:0] peek [4];
    logic [127:0] mres [4];
    logic         cmd_ready, row_ready, matrix_mode, load_id_en, load_en, push_en, pop_en;
    logic         write_en, mul_start, err_ovf, err_unf, busy;
    logic [127:0] data_out;
    logic [127:0] wr_row [4];
    logic [127:0] op_row [4];

    int checks = 0;
    int failures = 0;

    // Abstract model: stack depth per stack, capacity per stack, selected stack
    int depth [2];
    int cap [2] = '{32, 2};
    bit mode_m;

    localparam logic [7:0] S_NONE = 8'h00, S_LID = 8'h80, S_PUSH = 8'h60, S_POP = 8'h10;
    localparam logic [7:0] S_WR = 8'h08, S_MUL = 8'h04, S_OVF = 8'h02, S_UNF = 8'h01;
    logic [7:0] strobes;
    assign strobes = {load_id_en, load_en, push_en, pop_en, write_en, mul_start, err_ovf, err_unf};

    matrix_cmd_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .matrix_mode(matrix_mode), .load_id_en(load_id_en), .load_en(load_en),
        .push_en(push_en), .pop_en(pop_en), .write_en(write_en), .data_out(data_out),
        .wr_row_0(wr_row[0]), .wr_row_1(wr_row[1]), .wr_row_2(wr_row[2]), .wr_row_3(wr_row[3]),
        .peek_0(peek[0]), .peek_1(peek[1]), .peek_2(peek[2]), .peek_3(peek[3]),
        .mul_start(mul_start),
        .op_row_0(op_row[0]), .op_row_1(op_row[1]), .op_row_2(op_row[2]), .op_row_3(op_row[3]),
        .mul_done(mul_done),
        .mul_res_0(mres[0]), .mul_res_1(mres[1]), .mul_res_2(mres[2]), .mul_res_3(mres[3]),
        .err_ovf(err_ovf), .err_unf(err_unf), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_peeks();
        for (int i = 0; i < 4; i++) peek[i] = rnd128();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", {127'd0, cmd_ready}, 128'd1);
    endtask

    // Presents one command; returns in the cycle after the accepting edge
    task automatic issue(input logic [2:0] op, input logic md);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mode  = md;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_mode  = $urandom_range(0, 1);
    endtask

    task automatic do_mode(input logic md);
        issue(3'd1, md);
        mode_m = md;
        chk("mode_out", {127'd0, matrix_mode}, {127'd0, md});
        chk("mode_ready", {127'd0, cmd_ready}, 128'd1);
        chk("mode_strobes", {120'd0, strobes}, {120'd0, S_NONE});
    endtask

    task automatic do_push();
        logic [127:0] r [4];
        new_peeks();
        for (int i = 0; i < 4; i++) r[i] = peek[i];
        issue(3'd4, 1'b0);
        new_peeks();
        if (depth[mode_m] == cap[mode_m]) begin
            chk("push_rej_strobes", {120'd0, strobes}, {120'd0, S_OVF});
            chk("push_rej_ready", {127'd0, cmd_ready}, 128'd1);
            tick();
            chk("push_rej_after", {120'd0, strobes}, {120'd0, S_NONE});
        end else begin
            depth[mode_m]++;
            chk("push0_strobes", {120'd0, strobes}, {120'd0, S_PUSH});
            chk("push0_data", data_out, r[0]);
            chk("push0_busy", {127'd0, busy}, 128'd1);
            for (int k = 1; k < 4; k++) begin
                tick();
                chk("pushk_strobes", {120'd0, strobes}, {120'd0, S_NONE});
                chk("pushk_data", data_out, r[k]);
                chk("pushk_ready", {127'd0, cmd_ready}, 128'd0);
            end
            tick();
            chk("push_done_ready", {127'd0, cmd_ready}, 128'd1);
        end
    endtask

    task automatic do_pop();
        issue(3'd5, 1'b0);
        if (depth[mode_m] == 1) begin
            chk("pop_rej_strobes", {120'd0, strobes}, {120'd0, S_UNF});
            chk("pop_rej_ready", {127'd0, cmd_ready}, 128'd1);
            tick();
            chk("pop_rej_after", {120'd0, strobes}, {120'd0, S_NONE});
        end else begin
            depth[mode_m]--;
            chk("pop_strobes", {120'd0, strobes}, {120'd0, S_POP});
            chk("pop_ready", {127'd0, cmd_ready}, 128'd0);
            tick();
            chk("pop_after", {120'd0, strobes}, {120'd0, S_NONE});
            chk("pop_done_ready", {127'd0, cmd_ready}, 128'd1);
        end
    endtask

    task automatic do_loadid();
        issue(3'd2, 1'b0);
        chk("lid_strobes", {120'd0, strobes}, {120'd0, S_LID});
        tick();
        chk("lid_after", {120'd0, strobes}, {120'd0, S_NONE});
        chk("lid_ready", {127'd0, cmd_ready}, 128'd1);
    endtask

    task automatic do_nop(input logic [2:0] op);
        issue(op, 1'b1);
        chk("nop_strobes", {120'd0, strobes}, {120'd0, S_NONE});
        chk("nop_ready", {127'd0, cmd_ready}, 128'd1);
        chk("nop_mode", {127'd0, matrix_mode}, {127'd0, mode_m});
    endtask

    // LOAD or MULT: four rows with the given gap, then the expected write-back
    task automatic do_rows(input bit is_mult, input int gap);
        logic [127:0] r [4];
        logic [127:0] p [4];
        for (int i = 0; i < 4; i++) r[i] = rnd128();
        issue(is_mult ? 3'd6 : 3'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("row_ready", {127'd0, row_ready}, 128'd1);
            row_valid = 1'b1;
            row_data  = r[k];
            tick();
            row_valid = 1'b0;
            row_data  = rnd128();
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    chk("gap_strobes", {120'd0, strobes}, {120'd0, S_NONE});
                    tick();
                end
            end
        end
        chk("gather_mode", {127'd0, matrix_mode}, {127'd0, mode_m});
        if (is_mult) begin
            chk("mul_start", {120'd0, strobes}, {120'd0, S_MUL});
            for (int i = 0; i < 4; i++) chk("op_row", op_row[i], r[i]);
            for (int i = 0; i < 4; i++) p[i] = rnd128();
            for (int c = 0; c < 7; c++) begin
                tick();
                chk("mwait_strobes", {120'd0, strobes}, {120'd0, S_NONE});
            end
            mul_done = 1'b1;
            for (int i = 0; i < 4; i++) mres[i] = p[i];
            tick();
            mul_done = 1'b0;
            for (int i = 0; i < 4; i++) mres[i] = rnd128();
            chk("mult_wb_strobes", {120'd0, strobes}, {120'd0, S_WR});
            for (int i = 0; i < 4; i++) chk("mult_wr_row", wr_row[i], p[i]);
        end else begin
            chk("load_wb_strobes", {120'd0, strobes}, {120'd0, S_WR});
            for (int i = 0; i < 4; i++) chk("load_wr_row", wr_row[i], r[i]);
        end
        chk("wb_row_ready", {127'd0, row_ready}, 128'd0);
        tick();
        chk("wb_after", {120'd0, strobes}, {120'd0, S_NONE});
        chk("wb_ready", {127'd0, cmd_ready}, 128'd1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            peek[i] = '0;
            mres[i] = '0;
        end
        depth[0] = 1;
        depth[1] = 1;
        mode_m = 1'b0;

        // Reset held for one edge, then the hold window
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_strobes", {120'd0, strobes}, {120'd0, S_NONE});
        chk("rst_mode", {127'd0, matrix_mode}, 128'd0);
        chk("rst_data_out", data_out, 128'd0);
        chk("rst_wr_row", wr_row[0], 128'd0);
        chk("rst_row_ready", {127'd0, row_ready}, 128'd0);
        for (int c = 0; c < 4; c++) begin
            chk("rst_hold_ready", {127'd0, cmd_ready}, 128'd0);
            if (c < 3) tick();
        end
        tick();
        chk("rst_hold_done", {127'd0, cmd_ready}, 128'd1);
        chk("rst_busy", {127'd0, busy}, 128'd0);

        // Modelview push
        do_push();

        // Projection: push ok, push overflow, pop ok, pop underflow
        do_mode(1'b1);
        do_push();
        do_push();
        do_pop();
        do_pop();

        // LOAD with two-cycle row gaps, MULT with seven-cycle multiplier latency
        do_rows(1'b0, 2);
        do_rows(1'b1, 0);

        // Reset in the middle of a push sequence
        issue(3'd4, 1'b0);
        depth[mode_m]++;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        depth[0] = 1;
        depth[1] = 1;
        mode_m = 1'b0;
        chk("midrst_strobes", {120'd0, strobes}, {120'd0, S_NONE});
        chk("midrst_ready", {127'd0, cmd_ready}, 128'd0);
        chk("midrst_mode", {127'd0, matrix_mode}, 128'd0);
        chk("midrst_data", data_out, 128'd0);
        wait_ready();
        mul_done = 1'b1;
        for (int i = 0; i < 4; i++) mres[i] = rnd128();
        tick();
        mul_done = 1'b0;
        chk("stray_done_strobes", {120'd0, strobes}, {120'd0, S_NONE});
        chk("stray_done_ready", {127'd0, cmd_ready}, 128'd1);
        chk("stray_done_buf", wr_row[0], 128'd0);
        do_pop();
        do_mode(1'b1);
        do_pop();

        // Fill modelview to capacity, then one more
        do_mode(1'b0);
        for (int i = 0; i < 32; i++) do_push();
        do_nop(3'd7);
        do_loadid();

        // Random command traffic
        for (int n = 0; n < 120; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 9: do_push();
                2, 3:    do_pop();
                4:       do_mode(1'($urandom_range(0, 1)));
                5:       do_loadid();
                6:       do_nop(($urandom_range(0, 1) != 0) ? 3'd7 : 3'd0);
                7:       do_rows(1'b0, $urandom_range(0, 3));
                default: do_rows(1'b1, $urandom_range(0, 2));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
